// File: rtl/dff_ram_4x72_arbiter_if.sv
// Request/response bundle shared by the two RAM masters and the arbiter.
// master = requester side, slave = arbiter side.
interface dff_ram_4x72_arbiter_if #(
  parameter int DW = 72,
  parameter int AW = 2
);
  logic          req0_valid;
  logic          req0_ready;
  logic          req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;

  logic          req1_valid;
  logic          req1_ready;
  logic          req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata
  );
endinterface

// File: rtl/dff_ram_4x72_arbiter.sv
// Two-master round-robin arbiter/sequencer for the 4x72 DFF RAM (active-low en/wr).
// Optional power-up zero sweep of the RAM enabled by defining DFF_RAM_ARB_INIT_EN.
module dff_ram_4x72_arbiter #(
  parameter int DW = 72,
  parameter int AW = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dff_ram_4x72_arbiter_if.slave  bus,
  output logic                   ram_en,
  output logic                   ram_wr,
  output logic [AW-1:0]          ram_address,
  output logic [DW-1:0]          ram_wdata,
  input  logic [DW-1:0]          ram_rdata,
  output logic                   init_busy
);

  logic          run;
  logic          init_wr;
  logic [AW-1:0] init_addr;

`ifdef DFF_RAM_ARB_INIT_EN
  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] init_cnt;

  // The sweep counter doubles as the RAM address while zeroing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT)
        init_cnt <= init_cnt + AW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_cnt == '1) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  assign init_busy = (state == S_INIT);
  assign run       = (state == S_RUN);
  assign init_wr   = (state == S_INIT);
  assign init_addr = init_cnt;
`else
  assign init_busy = 1'b0;
  assign run       = 1'b1;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  logic          prio;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic          acc_id;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  // prio only matters when both masters ask in the same cycle
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && run) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = ~prio;
        grant1 = prio;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    accept    = grant0 | grant1;
    acc_id    = grant1;
    acc_we    = grant1 ? bus.req1_we    : bus.req0_we;
    acc_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    acc_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // After each accept the other master gets the next tie-break
  always_ff @(posedge clk) begin
    if (!rst_n)
      prio <= 1'b0;
    else if (accept)
      prio <= ~acc_id;
  end

  // Address and write data hold their last values on idle cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_en      <= 1'b1;
      ram_wr      <= 1'b1;
      ram_address <= '0;
      ram_wdata   <= '0;
    end else if (init_wr) begin
      ram_en      <= 1'b0;
      ram_wr      <= 1'b0;
      ram_address <= init_addr;
      ram_wdata   <= '0;
    end else if (accept) begin
      ram_en      <= 1'b0;
      ram_wr      <= ~acc_we;
      ram_address <= acc_addr;
      ram_wdata   <= acc_wdata;
    end else begin
      ram_en <= 1'b1;
      ram_wr <= 1'b1;
    end
  end

  logic s1_valid;
  logic s1_id;
  logic s2_valid;
  logic s2_id;

  // Stage 1 lines up with the RAM drive, stage 2 with the RAM output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
    end else begin
      s1_valid <= accept & ~acc_we;
      s1_id    <= acc_id;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

  assign bus.rsp0_valid = s2_valid & ~s2_id;
  assign bus.rsp1_valid = s2_valid & s2_id;
  assign bus.rsp0_rdata = ram_rdata;
  assign bus.rsp1_rdata = ram_rdata;

endmodule

// File: tb/tb_dff_ram_4x72_arbiter.sv
// Scoreboard bench for dff_ram_4x72_arbiter: directed vectors push expected
// read responses, a negedge monitor pops and compares them.
module tb_dff_ram_4x72_arbiter;
  localparam int DW = 72;
  localparam int AW = 2;
  localparam logic [DW-1:0] PAT_A = {9{8'hAA}};
  localparam logic [DW-1:0] PAT_5 = {9{8'h55}};
`ifdef DFF_RAM_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_en;
  logic          ram_wr;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          init_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dff_ram_4x72_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  dff_ram_4x72_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ram_en      (ram_en),
    .ram_wr      (ram_wr),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .init_busy   (init_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM, pre-filled with a non-zero pattern so a zero sweep is visible
  logic [DW-1:0] mem [4] = '{default: {9{8'hC3}}};

  always @(posedge clk) begin
    if (!ram_en) begin
      if (!ram_wr) mem[ram_address] <= ram_wdata;
      else         ram_rdata <= mem[ram_address];
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every strobe must match the oldest pending read, at its cycle
  always @(negedge clk) begin
    if (bus.rsp0_valid || bus.rsp1_valid) begin
      checkOutput("rsp_exclusive", bus.rsp0_valid & bus.rsp1_valid, 1'b0);
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", bus.rsp0_valid | bus.rsp1_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rsp_id", bus.rsp1_valid, mon_e.id == 1);
        checkOutput("rsp_data", (mon_e.id == 1) ? bus.rsp1_rdata : bus.rsp0_rdata, mon_e.data);
        checkOutput("rsp_cycle", cyc, mon_e.cyc);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checkOutput("rsp_missing", bus.rsp0_valid | bus.rsp1_valid, 1'b1);
      void'(sb.pop_front());
    end
  end

  // One cycle of stimulus; g is the hand-computed grant (-1 = none)
  task automatic applyStimulus(input logic v0, input logic we0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic v1, input logic we1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input int g, input logic [DW-1:0] expRd);
    logic          gwe;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    bus.req0_valid = v0;
    bus.req0_we    = we0;
    bus.req0_addr  = a0;
    bus.req0_wdata = d0;
    bus.req1_valid = v1;
    bus.req1_we    = we1;
    bus.req1_addr  = a1;
    bus.req1_wdata = d1;
    gwe = (g == 1) ? we1 : we0;
    ga  = (g == 1) ? a1 : a0;
    gd  = (g == 1) ? d1 : d0;
    #1;
    checkOutput("req0_ready", bus.req0_ready, g == 0);
    checkOutput("req1_ready", bus.req1_ready, g == 1);
    if (g >= 0 && !gwe) sb.push_back('{g, expRd, cyc + 2});
    @(posedge clk);
    #1;
    checkOutput("ram_en", ram_en, g < 0);
    if (g >= 0) begin
      checkOutput("ram_wr", ram_wr, !gwe);
      checkOutput("ram_address", ram_address, ga);
      if (gwe) checkOutput("ram_wdata", ram_wdata, gd);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 2'd0, '0, -1, '0);
  endtask

  task automatic waitInit();
`ifdef DFF_RAM_ARB_INIT_EN
    int n;
    n = 0;
    #1;
    while (init_busy && n < 20) begin
      checkOutput("init_ready0", bus.req0_ready, 1'b0);
      n++;
      @(negedge clk);
      #1;
    end
    checkOutput("init_cycles", n, 4);
`else
    #0;
`endif
  endtask

  task automatic doReset(input bit keepReq0);
    rst_n          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_we    = 1'b0;
    bus.req0_addr  = 2'd1;
    bus.req0_wdata = '0;
    bus.req1_valid = 1'b1;
    bus.req1_we    = 1'b0;
    bus.req1_addr  = 2'd0;
    bus.req1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ram_en", ram_en, 1'b1);
    checkOutput("rst_ram_wr", ram_wr, 1'b1);
    checkOutput("rst_ram_address", ram_address, '0);
    checkOutput("rst_ram_wdata", ram_wdata, '0);
    checkOutput("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    checkOutput("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
    checkOutput("rst_req0_ready", bus.req0_ready, 1'b0);
    checkOutput("rst_req1_ready", bus.req1_ready, 1'b0);
    checkOutput("rst_init_busy", init_busy, INIT_EN);
    bus.req1_valid = 1'b0;
    if (!keepReq0) bus.req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    waitInit();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start, init sweep %0d", INIT_EN);
    doReset(1'b0);

    // Idle: no requests, RAM stays disabled
    idle(3);

    // Single write then read by master 0, plus a write by master 1
    applyStimulus(1'b1, 1'b1, 2'd2, PAT_A, 1'b0, 1'b0, 2'd0, '0, 0, '0);
    applyStimulus(1'b1, 1'b0, 2'd2, '0, 1'b0, 1'b0, 2'd0, '0, 0, PAT_A);
    applyStimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 2'd3, PAT_5, 1, '0);
    idle(3);

    // Contention straight after reset: grants alternate 0,1,0,1
    doReset(1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 2'd2, '0, 1'b1, 1'b0, 2'd3, '0, i % 2,
                    INIT_EN ? '0 : ((i % 2) ? PAT_5 : PAT_A));
    idle(3);

    // Back-to-back: master 1 writes 1..4 to addr 0..3, then reads 3..0
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b1, AW'(i), DW'(i + 1), 1, '0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, AW'(3 - i), '0, 1, DW'(4 - i));
    idle(3);

    // Reset on the edge after a read accept: no response, prio back to 0
    bus.req0_valid = 1'b1;
    bus.req0_we    = 1'b0;
    bus.req0_addr  = 2'd1;
    #1;
    checkOutput("midrst_req0_ready", bus.req0_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_ram_en", ram_en, 1'b1);
    checkOutput("midrst_rsp0", bus.rsp0_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midrst_rsp0_late", bus.rsp0_valid, 1'b0);
    checkOutput("midrst_rsp1_late", bus.rsp1_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    waitInit();
    applyStimulus(1'b1, 1'b0, 2'd1, '0, 1'b1, 1'b0, 2'd0, '0, 0, INIT_EN ? '0 : DW'(2));
    applyStimulus(1'b0, 1'b0, 2'd1, '0, 1'b1, 1'b0, 2'd0, '0, 1, INIT_EN ? '0 : DW'(1));
    idle(3);

`ifdef DFF_RAM_ARB_INIT_EN
    // Master 0 held valid across release is taken on the first RUN cycle
    doReset(1'b1);
    applyStimulus(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, 2'd0, '0, 0, '0);
    applyStimulus(1'b1, 1'b0, 2'd3, '0, 1'b0, 1'b0, 2'd0, '0, 0, '0);
    applyStimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, 2'd0, '0, 1, '0);
    applyStimulus(1'b1, 1'b0, 2'd2, '0, 1'b0, 1'b0, 2'd0, '0, 0, '0);
    idle(3);
`endif

    checkOutput("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
